// File: rtl/rs_syndrome_seq.sv
// rs_syndrome_seq: serial RS(7,5) GF(8) syndrome sequencer (S1, S2 by Horner); define RS_SYN_STATS_EN to add cw_count/err_count
module rs_gf_mul #(
    parameter int SW = 3,
    parameter int N  = 7
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    output logic [SW-1:0] y
);
    logic [SW:0] s;
    always_comb begin
        s = {1'b0, a} + {1'b0, b} - (SW+1)'(1);
        y = (a == '0) ? '0 : (s > (SW+1)'(N)) ? SW'(s - (SW+1)'(N)) : SW'(s);
    end
endmodule

module rs_gf_add (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] y
);
    // field generated by x^3 + x + 1; index k>0 is alpha^(k-1)
    localparam logic [2:0] POLY [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
    localparam logic [2:0] IDX  [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd3, 3'd7, 3'd5, 3'd6};
    assign y = IDX[POLY[a] ^ POLY[b]];
endmodule

module rs_syndrome_seq #(
    parameter int CW_LEN = 7,
    parameter int SW     = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    input  logic [SW-1:0] sym_in,
    input  logic          sym_valid,
    input  logic          sym_last,
    output logic          sym_ready,
    output logic [SW-1:0] syn1,
    output logic [SW-1:0] syn2,
    output logic          syn_err,
    output logic          frame_err,
    output logic          syn_valid,
    input  logic          syn_ready
`ifdef RS_SYN_STATS_EN
    ,
    output logic [7:0]    cw_count,
    output logic [7:0]    err_count
`endif
);
    localparam int CNT_W = $clog2(CW_LEN + 1);
    localparam logic [SW-1:0] ALPHA = SW'(2);
    localparam logic [SW-1:0] ALPHA2 = SW'(3);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CW_LEN - 1);
    typedef enum logic {COLLECT, OUTPUT} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [SW-1:0] acc1, acc2, mul1, mul2, add1, add2, nxt1, nxt2;
    logic fe_acc, first, at_last, accept, fe_nxt, err_nxt;
    rs_gf_mul #(.SW(SW), .N(CW_LEN)) u_mul1 (.a(acc1), .b(ALPHA), .y(mul1));
    rs_gf_mul #(.SW(SW), .N(CW_LEN)) u_mul2 (.a(acc2), .b(ALPHA2), .y(mul2));
    rs_gf_add u_add1 (.a(mul1), .b(sym_in), .y(add1));
    rs_gf_add u_add2 (.a(mul2), .b(sym_in), .y(add2));
    assign sym_ready = (state == COLLECT) && !abort;
    always_comb begin
        accept  = sym_valid && sym_ready;
        first   = cnt == '0;
        at_last = cnt == LAST;
        nxt1    = first ? sym_in : add1;
        nxt2    = first ? sym_in : add2;
        // a codeword is always CW_LEN symbols; a misplaced or missing sym_last only flags it
        fe_nxt  = first ? (sym_last && CW_LEN != 1) : (fe_acc || (sym_last != at_last));
        err_nxt = (nxt1 != '0) || (nxt2 != '0);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            cnt       <= '0;
            acc1      <= '0;
            acc2      <= '0;
            fe_acc    <= 1'b0;
            syn_valid <= 1'b0;
            syn1      <= '0;
            syn2      <= '0;
            syn_err   <= 1'b0;
            frame_err <= 1'b0;
        end else if (state == OUTPUT) begin
            if (syn_ready) begin
                syn_valid <= 1'b0;
                state     <= COLLECT;
            end
        end else if (abort) begin
            cnt    <= '0;
            fe_acc <= 1'b0;
        end else if (accept) begin
            acc1   <= nxt1;
            acc2   <= nxt2;
            fe_acc <= fe_nxt;
            cnt    <= at_last ? '0 : cnt + CNT_W'(1);
            if (at_last) begin
                state     <= OUTPUT;
                syn_valid <= 1'b1;
                syn1      <= nxt1;
                syn2      <= nxt2;
                syn_err   <= err_nxt;
                frame_err <= fe_nxt;
            end
        end
    end
`ifdef RS_SYN_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_count  <= '0;
            err_count <= '0;
        end else if (accept && at_last) begin
            if (cw_count != 8'hff) cw_count <= cw_count + 8'd1;
            if ((err_nxt || fe_nxt) && err_count != 8'hff) err_count <= err_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_rs_syndrome_seq.sv
// tb_rs_syndrome_seq: randomized bench with a direct polynomial-evaluation model of the syndrome sequencer
module tb_rs_syndrome_seq;
    logic clk = 1'b0, rst_n = 1'b0, abort = 1'b0, sym_valid = 1'b0, sym_last = 1'b0, syn_ready = 1'b1;
    logic [2:0] sym_in = 3'd0;
    logic sym_ready, syn_err, frame_err, syn_valid;
    logic [2:0] syn1, syn2;
`ifdef RS_SYN_STATS_EN
    logic [7:0] cw_count, err_count;
    int exp_cw = 0, exp_ec = 0;
`endif
    typedef logic [2:0] sv_t [7];
    typedef logic lv_t [7];
    typedef struct packed {logic [2:0] s1; logic [2:0] s2; logic err; logic fe;} res_t;
    int checks = 0, errors = 0, rdy_mode = 0;
    res_t exp_r;
    logic busy = 1'b0;
    int cur_n = 0;
    sv_t cw_sym;
    lv_t cw_last;

    rs_syndrome_seq dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_last(sym_last), .sym_ready(sym_ready), .syn1(syn1), .syn2(syn2), .syn_err(syn_err),
        .frame_err(frame_err), .syn_valid(syn_valid), .syn_ready(syn_ready)
`ifdef RS_SYN_STATS_EN
        , .cw_count(cw_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] apow(input int e);
        logic [2:0] p = 3'd1;
        for (int i = 0; i < e % 7; i++) p = {p[1:0], 1'b0} ^ (p[2] ? 3'b011 : 3'b000);
        return p;
    endfunction

    function automatic logic [2:0] to_idx(input logic [2:0] p);
        for (int e = 0; e < 7; e++) if (p != 3'd0 && apow(e) == p) return 3'(e + 1);
        return 3'd0;
    endfunction

    // r(alpha^j) = sum over symbols of r_k * alpha^(j*degree), symbol 0 has degree 6
    function automatic logic [2:0] eval(input sv_t s, input int j);
        logic [2:0] acc = 3'd0;
        for (int k = 0; k < 7; k++) if (s[k] != 3'd0) acc ^= apow(int'(s[k]) - 1 + j * (6 - k));
        return to_idx(acc);
    endfunction

    function automatic res_t ref_model(input sv_t s, input lv_t l);
        res_t r;
        r.s1 = eval(s, 1);
        r.s2 = eval(s, 2);
        r.err = (r.s1 != 3'd0) || (r.s2 != 3'd0);
        r.fe = !l[6];
        for (int k = 0; k < 6; k++) r.fe |= l[k];
        return r;
    endfunction

    function automatic res_t complete(input sv_t s, input lv_t l, input logic [2:0] s6, input logic l6);
        sv_t ss = s;
        lv_t ll = l;
        ss[6] = s6;
        ll[6] = l6;
        return ref_model(ss, ll);
    endfunction

    function automatic lv_t mk_last(input int pos);
        lv_t l;
        for (int k = 0; k < 7; k++) l[k] = (k == pos);
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cur_n <= 0;
`ifdef RS_SYN_STATS_EN
            exp_cw <= 0;
            exp_ec <= 0;
`endif
        end else if (busy) begin
            if (syn_ready) busy <= 1'b0;
        end else if (abort) begin
            cur_n <= 0;
        end else if (sym_valid) begin
            cw_sym[cur_n] <= sym_in;
            cw_last[cur_n] <= sym_last;
            if (cur_n == 6) begin
                res_t r;
                r = complete(cw_sym, cw_last, sym_in, sym_last);
                exp_r <= r;
                busy <= 1'b1;
                cur_n <= 0;
`ifdef RS_SYN_STATS_EN
                exp_cw <= (exp_cw == 255) ? 255 : exp_cw + 1;
                if (r.err || r.fe) exp_ec <= (exp_ec == 255) ? 255 : exp_ec + 1;
`endif
            end else begin
                cur_n <= cur_n + 1;
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("sym_ready", sym_ready, !busy && !abort);
            check("syn_valid", syn_valid, busy);
            if (busy) begin
                check("syn1", syn1, exp_r.s1);
                check("syn2", syn2, exp_r.s2);
                check("syn_err", syn_err, exp_r.err);
                check("frame_err", frame_err, exp_r.fe);
            end
`ifdef RS_SYN_STATS_EN
            check("cw_count", cw_count, exp_cw);
            check("err_count", err_count, exp_ec);
`endif
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            syn_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            sym_valid = 1'b0;
            sym_in = 3'($urandom);
            sym_last = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic [2:0] s, input logic l);
        int t = 0;
        sym_in = s;
        sym_last = l;
        sym_valid = 1'b1;
        @(negedge clk);
        while (!sym_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t == 200) check("accept_timeout", sym_ready, 1);
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        sym_valid = 1'($urandom);
        sym_in = 3'($urandom);
        @(posedge clk);
        #1;
        abort = 1'b0;
        sym_valid = 1'b0;
    endtask

    task automatic send(input sv_t s, input int lastpos, input bit rnd);
        for (int k = 0; k < 7; k++) begin
            if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if (rnd && $urandom_range(0, 49) == 0) pulse_abort();
            put(s[k], k == lastpos);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (busy) check("drain_timeout", syn_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_syn_valid"}, syn_valid, 0);
        check({tag, "_syn1"}, syn1, 0);
        check({tag, "_syn2"}, syn2, 0);
        check({tag, "_syn_err"}, syn_err, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_sym_ready"}, sym_ready, 1);
    endtask

    initial begin
        sv_t zero, e6, e0, rs;
        zero = '{default: 3'd0};
        e6 = zero;
        e6[0] = 3'd1;
        e0 = zero;
        e0[6] = 3'd1;
        check("pin_zero", ref_model(zero, mk_last(6)), 8'h00);
        check("pin_r6", ref_model(e6, mk_last(6)), 8'hFA);
        check("pin_r0", ref_model(e0, mk_last(6)), 8'h26);
        check("pin_early_last", ref_model(zero, mk_last(3)), 8'h01);
        check("pin_no_last", ref_model(zero, mk_last(7)), 8'h01);
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        send(zero, 6, 0);
        wait_idle();
        check("zero_syn_err", syn_err, 0);
        send(e6, 6, 0);
        wait_idle();
        check("r6_syn1", syn1, 7);
        check("r6_syn2", syn2, 6);
        rdy_mode = 2;
        send(e0, 6, 0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_syn1", syn1, 1);
        check("hold_syn2", syn2, 1);
        rdy_mode = 0;
        wait_idle();
        for (int k = 0; k < 7; k++) rs[k] = 3'($urandom);
        send(rs, 3, 0);
        wait_idle();
        check("early_last_fe", frame_err, 1);
        send(rs, 7, 0);
        wait_idle();
        check("no_last_fe", frame_err, 1);
        put(3'd5, 0);
        put(3'd3, 0);
        put(3'd7, 0);
        abort = 1'b1;
        sym_valid = 1'b1;
        sym_in = 3'd4;
        @(posedge clk);
        #1;
        abort = 1'b0;
        sym_valid = 1'b0;
        send(zero, 6, 0);
        wait_idle();
        check("abort_syn1", syn1, 0);
        check("abort_fe", frame_err, 0);
        send(e0, 6, 0);
        wait_idle();
        put(3'd2, 0);
        put(3'd6, 0);
        put(3'd1, 0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef RS_SYN_STATS_EN
        repeat (256) send(e0, 6, 0);
        wait_idle();
        check("cw_count_sat", cw_count, 255);
        check("err_count_sat", err_count, 255);
`endif
        rdy_mode = 1;
        repeat (300) begin
            for (int k = 0; k < 7; k++) rs[k] = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom);
            send(rs, ($urandom_range(0, 6) == 0) ? $urandom_range(0, 7) : 6, 1);
        end
        rdy_mode = 0;
        idle(2);
        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_syndrome_seq.md
Name: rs_syndrome_seq

Overview:
Sequencing controller for the RS(7,5) decoder front end over GF(8).
- Accepts one received codeword serially, highest-degree symbol first, over a valid/ready handshake.
- Drives the existing GF adder and GF multiplier through Horner evaluation to produce syndromes S1 = r(alpha) and S2 = r(alpha^2).
- Presents both syndromes, an error flag and a framing flag on an output handshake to the downstream error locator.
- All symbols use index form: 0 is the zero element; k in 1..7 is alpha^(k-1).

Parameters:
CW_LEN, 7, codeword length in symbols; must equal the GF order minus 1.
SW, 3, symbol width in bits; must match the codebase symbol width.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
abort  in  1  synchronous flush of the codeword in progress
sym_in  in  SW  received symbol, index form
sym_valid  in  1  sym_in is valid
sym_last  in  1  marks the sender's final symbol of a codeword
sym_ready  out  1  block accepts sym_in this cycle
syn1  out  SW  syndrome S1, index form
syn2  out  SW  syndrome S2, index form
syn_err  out  1  S1 != 0 or S2 != 0
frame_err  out  1  sym_last position did not match CW_LEN
syn_valid  out  1  syndrome outputs are valid
syn_ready  in  1  downstream accepts the syndromes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = COLLECT, cnt=0.
  - acc1=acc2=0, frame_err=0.
  - syn_valid=0; syn1, syn2, syn_err=0.
  - Any partial codeword is discarded.
- States: COLLECT and OUTPUT.
- Handshake rules:
  - Input accept = sym_valid & sym_ready.
  - sym_ready = (state==COLLECT) & !abort. This is combinational, with no dependence on sym_valid.
- COLLECT, accept with cnt==0:
  - acc1 <= sym_in, acc2 <= sym_in.
  - frame_err <= sym_last & (CW_LEN!=1).
  - cnt <= 1.
- COLLECT, accept with cnt>0:
  - acc1 <= GFadd(GFmul(acc1, 3'd2), sym_in), where index 2 = alpha.
  - acc2 <= GFadd(GFmul(acc2, 3'd3), sym_in), where index 3 = alpha^2.
  - Use two multiplier and two adder instances.
  - The accumulator drives the multiplier's zero-checked operand; the constant drives the other operand.
  - Set frame_err if sym_last=1 while cnt != CW_LEN-1, or if sym_last=0 while cnt == CW_LEN-1.
- Codeword completion:
  - On the accept with cnt==CW_LEN-1: cnt <= 0, state <= OUTPUT.
  - syn1/syn2 take the updated accumulator values; syn_err is computed from them.
  - syn_valid rises the next cycle, so latency is 1 clock from the last accepted symbol.
- Framing errors: the codeword is always exactly CW_LEN symbols. An early sym_last does not truncate it; it only sets frame_err.
- OUTPUT state:
  - syn1, syn2, syn_err, frame_err are held stable while syn_valid=1 & syn_ready=0.
  - On syn_valid & syn_ready: syn_valid <= 0, state <= COLLECT.
  - No symbol is accepted in that cycle. Minimum period is CW_LEN+1 clocks per codeword.
- abort:
  - In COLLECT, abort=1 sets cnt <= 0 and frame_err <= 0, and the accumulators are ignored. No symbol is accepted that cycle.
  - In OUTPUT, abort has no effect; completed syndromes are never dropped.
- Arithmetic:
  - Multiply by a nonzero constant: result index = acc+c-1, minus CW_LEN if it exceeds CW_LEN; acc==0 gives 0.
  - Addition is XOR of polynomial forms via the lookup tables.
  - Evaluate index sums at SW+1 bits minimum to avoid wrap.

Optional Feature:
RS_SYN_STATS_EN
- When defined, adds two outputs:
  - cw_count [7:0]: completed codewords.
  - err_count [7:0]: completed codewords with syn_err or frame_err.
- Both counters increment on the COLLECT->OUTPUT transition, saturate at 255, clear only on rst_n, and are unaffected by abort.
- When undefined, the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- Seven zero symbols, sym_last on the 7th, syn_ready=1 -> syn1=0, syn2=0, syn_err=0, frame_err=0, syn_valid 1 cycle after the 7th accept.
- Symbols {1,0,0,0,0,0,0} (r6=1) -> syn1=7 (alpha^6), syn2=6 (alpha^12=alpha^5), syn_err=1.
- Symbols {0,0,0,0,0,0,1} -> syn1=1, syn2=1, syn_err=1; hold syn_ready=0 for 5 cycles -> outputs stable, sym_ready=0 throughout.
- sym_last asserted on the 4th symbol of 7 -> outputs after the 7th symbol with frame_err=1; sym_last missing entirely -> frame_err=1.
- 3 symbols accepted, then abort with sym_valid=1 -> that symbol not accepted; the next 7 zeros give syn1=syn2=0, frame_err=0. Assert rst_n=0 mid-codeword -> immediate return to the reset values.
- With RS_SYN_STATS_EN, 256 error codewords -> err_count=255, cw_count=255 (both saturated).
